// File: rtl/mem_port_arbiter.sv
// Shares the external memory read and write ports between NB_REQ requesters with
// per-port round-robin arbitration and read-return routing. `MEM_ARB_LOCK_EN adds req_lock.
module mem_port_rr #(
    parameter int NB_REQ = 2,
    parameter int IW     = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic [NB_REQ-1:0] cand,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NB_REQ-1:0] lock,
`endif
    output logic              gnt_vld,
    output logic [IW-1:0]     gnt_idx
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] nxt;
    int            idx;
`ifdef MEM_ARB_LOCK_EN
    logic          lock_act;
    logic [IW-1:0] lock_own;
`endif

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int j = 0; j < NB_REQ; j++) begin
            idx = (int'(ptr) + j) % NB_REQ;
            if (!gnt_vld && cand[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
`ifdef MEM_ARB_LOCK_EN
        // a lock owner that is requesting wins regardless of the rotation
        if (lock_act && cand[lock_own]) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_own;
        end
`endif
    end

    assign nxt = (gnt_idx == IW'(NB_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            ptr <= '0;
`ifdef MEM_ARB_LOCK_EN
            lock_act <= 1'b0;
            lock_own <= '0;
`endif
        end else if (gnt_vld) begin
`ifdef MEM_ARB_LOCK_EN
            if (lock[gnt_idx]) begin
                lock_act <= 1'b1;
                lock_own <= gnt_idx;
                ptr      <= gnt_idx;
            end else if (!lock_act || gnt_idx == lock_own) begin
                lock_act <= 1'b0;
                ptr      <= nxt;
            end
`else
            ptr <= nxt;
`endif
        end
    end
endmodule

module mem_port_arbiter #(
    parameter int NB_REQ           = 2,
    parameter int ADDR_WIDTH       = 20,
    parameter int DATA_WIDTH       = 32,
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_in,
    input  logic [NB_REQ-1:0]            req_valid,
    output logic [NB_REQ-1:0]            req_ready,
    input  logic [NB_REQ-1:0]            req_we,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NB_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NB_REQ-1:0]            req_lock,
`endif
    output logic [NB_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         ext_mem_read_en,
    output logic [ADDR_WIDTH-1:0]        ext_mem_read_addr,
    input  logic [DATA_WIDTH-1:0]        ext_mem_qout,
    output logic                         ext_mem_write_en,
    output logic [ADDR_WIDTH-1:0]        ext_mem_write_addr,
    output logic [DATA_WIDTH-1:0]        ext_mem_din
);
    localparam int IW     = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int STAGES = MEM_READ_LATENCY - 1;

    logic [NB_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
    logic [NB_REQ-1:0][DATA_WIDTH-1:0] wdata_a;
    logic [NB_REQ-1:0]                 rd_cand, wr_cand;
    logic                              rd_gnt, wr_gnt;
    logic [IW-1:0]                     rd_idx, wr_idx;
    logic [STAGES:0]                   vld_pipe;
    logic [STAGES:0][IW-1:0]           id_pipe;

    assign addr_a  = req_addr;
    assign wdata_a = req_wdata;
    assign rd_cand = rst_in ? '0 : (req_valid & ~req_we);
    assign wr_cand = rst_in ? '0 : (req_valid & req_we);

    mem_port_rr #(.NB_REQ(NB_REQ), .IW(IW)) u_rd_arb (
        .clk(clk), .rst_in(rst_in), .cand(rd_cand),
`ifdef MEM_ARB_LOCK_EN
        .lock(req_lock),
`endif
        .gnt_vld(rd_gnt), .gnt_idx(rd_idx)
    );

    mem_port_rr #(.NB_REQ(NB_REQ), .IW(IW)) u_wr_arb (
        .clk(clk), .rst_in(rst_in), .cand(wr_cand),
`ifdef MEM_ARB_LOCK_EN
        .lock(req_lock),
`endif
        .gnt_vld(wr_gnt), .gnt_idx(wr_idx)
    );

    always_comb begin
        req_ready          = '0;
        ext_mem_read_en    = 1'b0;
        ext_mem_read_addr  = '0;
        ext_mem_write_en   = 1'b0;
        ext_mem_write_addr = '0;
        ext_mem_din        = '0;
        if (rd_gnt) begin
            req_ready[rd_idx] = 1'b1;
            ext_mem_read_en   = 1'b1;
            ext_mem_read_addr = addr_a[rd_idx];
        end
        if (wr_gnt) begin
            req_ready[wr_idx]  = 1'b1;
            ext_mem_write_en   = 1'b1;
            ext_mem_write_addr = addr_a[wr_idx];
            ext_mem_din        = wdata_a[wr_idx];
        end
    end

    // stage STAGES lines up with the cycle the memory presents the word
    always_ff @(posedge clk) begin
        if (rst_in) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= rd_gnt;
            id_pipe[0]  <= rd_idx;
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (vld_pipe[STAGES] && !rst_in) begin
            rsp_valid[id_pipe[STAGES]] = 1'b1;
            rsp_data                   = ext_mem_qout;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: NB_REQ=3, latency 3, read-before-write memory model,
// per-cycle comparison against a grant/response model plus directed literal checks.
module tb_mem_port_arbiter;
    localparam int NB = 3, AW = 20, DW = 32, LAT = 3;

    logic clk = 1'b0;
    logic rst_in;
    logic [NB-1:0] req_valid, req_ready, req_we, rsp_valid;
    logic [NB-1:0][AW-1:0] a_arr;
    logic [NB-1:0][DW-1:0] d_arr;
    logic [NB*AW-1:0] req_addr;
    logic [NB*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_data, ext_mem_qout, ext_mem_din;
    logic ext_mem_read_en, ext_mem_write_en;
    logic [AW-1:0] ext_mem_read_addr, ext_mem_write_addr;
`ifdef MEM_ARB_LOCK_EN
    logic [NB-1:0] req_lock;
`endif
    int total = 0, bad = 0, cyc = 0;

    assign req_addr  = a_arr;
    assign req_wdata = d_arr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_READ_LATENCY(LAT)) dut (
        .clk(clk), .rst_in(rst_in), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ext_mem_read_en(ext_mem_read_en), .ext_mem_read_addr(ext_mem_read_addr),
        .ext_mem_qout(ext_mem_qout), .ext_mem_write_en(ext_mem_write_en),
        .ext_mem_write_addr(ext_mem_write_addr), .ext_mem_din(ext_mem_din)
    );

    // memory: read sampled at the accept edge before the same-edge write lands
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] qp [0:LAT-1];
    bit mem_init;
    assign ext_mem_qout = qp[LAT-1];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem_init <= 1'b1;
        end else if (ext_mem_write_en) mem[ext_mem_write_addr[7:0]] <= ext_mem_din;
        qp[0] <= ext_mem_read_en ? mem[ext_mem_read_addr[7:0]] : 32'hBAD0_BAD0;
        for (int s = 1; s < LAT; s++) qp[s] <= qp[s-1];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // model: pointers per port, lock state, queue of responses due at a cycle
    typedef struct { int due; int k; logic [DW-1:0] data; } rsp_t;
    rsp_t rq[$];
    int m_ptr[2];
`ifdef MEM_ARB_LOCK_EN
    bit m_act[2];
    int m_own[2];
`endif

    function automatic int pick(input int p);
        logic [NB-1:0] c;
        c = req_valid & ((p == 0) ? ~req_we : req_we);
        if (rst_in) return -1;
`ifdef MEM_ARB_LOCK_EN
        if (m_act[p] && c[m_own[p]]) return m_own[p];
`endif
        for (int j = 0; j < NB; j++)
            if (c[(m_ptr[p] + j) % NB]) return (m_ptr[p] + j) % NB;
        return -1;
    endfunction

    task automatic adv(input int p, input int g);
`ifdef MEM_ARB_LOCK_EN
        if (req_lock[g]) begin
            m_act[p] = 1'b1; m_own[p] = g; m_ptr[p] = g;
        end else if (!m_act[p] || g == m_own[p]) begin
            m_act[p] = 1'b0; m_ptr[p] = (g + 1) % NB;
        end
`else
        m_ptr[p] = (g + 1) % NB;
`endif
    endtask

    always @(negedge clk) begin
        int gr, gw;
        logic [NB-1:0] er, ev;
        logic [DW-1:0] ed;
        rsp_t e;
        gr = pick(0);
        gw = pick(1);
        er = '0;
        if (gr >= 0) er[gr] = 1'b1;
        if (gw >= 0) er[gw] = 1'b1;
        chk("ready", req_ready, er);
        chk("ren", ext_mem_read_en, gr >= 0);
        chk("raddr", ext_mem_read_addr, (gr >= 0) ? a_arr[gr] : AW'(0));
        chk("wen", ext_mem_write_en, gw >= 0);
        chk("waddr", ext_mem_write_addr, (gw >= 0) ? a_arr[gw] : AW'(0));
        chk("din", ext_mem_din, (gw >= 0) ? d_arr[gw] : DW'(0));
        ev = '0;
        ed = '0;
        if (!rst_in && rq.size() > 0 && rq[0].due == cyc) begin
            ev[rq[0].k] = 1'b1;
            ed = rq[0].data;
        end
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_data", rsp_data, ed);
        if (rst_in) begin
            m_ptr = '{0, 0};
`ifdef MEM_ARB_LOCK_EN
            m_act = '{0, 0};
            m_own = '{0, 0};
`endif
            rq.delete();
        end else begin
            if (gr >= 0) begin
                e.due = cyc + LAT; e.k = gr; e.data = mem[a_arr[gr][7:0]];
                rq.push_back(e);
                adv(0, gr);
            end
            if (gw >= 0) adv(1, gw);
        end
        while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req_valid = '0;
`ifdef MEM_ARB_LOCK_EN
        req_lock = '0;
`endif
    endtask

    task automatic rd(input int i, input int a);
        req_valid[i] = 1'b1; req_we[i] = 1'b0; a_arr[i] = AW'(a);
    endtask

    task automatic wr(input int i, input int a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1; req_we[i] = 1'b1; a_arr[i] = AW'(a); d_arr[i] = d;
    endtask

    initial begin
        rst_in = 1'b1; req_valid = '0; req_we = '0; a_arr = '0; d_arr = '0;
`ifdef MEM_ARB_LOCK_EN
        req_lock = '0;
`endif
        for (int i = 0; i < NB; i++) rd(i, 'h10 + i);
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_ren", ext_mem_read_en, 0);
        chk("rst_wen", ext_mem_write_en, 0);
        chk("rst_rsp", rsp_valid, 0);
        tick();
        rst_in = 1'b0;

        // rotation 0,1,2,0,1,2 with responses three cycles behind
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rot_gnt", req_ready, 1 << (c % NB));
            if (c >= LAT) begin
                chk("rot_rsp", rsp_valid, 1 << ((c - LAT) % NB));
                chk("rot_data", rsp_data, 32'hA000_0010 + (c - LAT) % NB);
            end
            tick();
        end
        clr();

        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle_ren", ext_mem_read_en, 0);
            chk("idle_wen", ext_mem_write_en, 0);
            tick();
        end
        rd(1, 'h20);
        @(negedge clk);
        chk("single_gnt", req_ready, 3'b010);
        tick(); clr();

        // same-address read and write in one cycle, then re-read
        wr(0, 'h40, 32'hDEADBEEF); rd(1, 'h40);
        @(negedge clk);
        chk("par_ready", req_ready, 3'b011);
        chk("par_din", ext_mem_din, 32'hDEADBEEF);
        chk("par_raddr", ext_mem_read_addr, 'h40);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("reread_gnt", req_ready, 3'b010);
        tick(); clr();
        @(negedge clk); tick();
        @(negedge clk);
        chk("old_rsp", rsp_valid, 3'b010);
        chk("old_data", rsp_data, 32'hA000_0040);
        tick();
        @(negedge clk);
        chk("new_data", rsp_data, 32'hDEADBEEF);
        tick();

        for (int i = 0; i < NB; i++) wr(i, 'h50 + i, DW'(i));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("wr_rot", req_ready, 1 << ((c + 1) % NB));
            tick();
        end
        clr();

        rd(0, 'h11); tick(); clr();
        rd(1, 'h12); tick(); clr();
        rd(0, 'h13); tick(); clr();
        @(negedge clk);
        chk("lat_rsp0", rsp_valid, 3'b001); chk("lat_d0", rsp_data, 32'hA000_0011);
        tick();
        @(negedge clk);
        chk("lat_rsp1", rsp_valid, 3'b010); chk("lat_d1", rsp_data, 32'hA000_0012);
        tick();
        @(negedge clk);
        chk("lat_rsp2", rsp_valid, 3'b001); chk("lat_d2", rsp_data, 32'hA000_0013);
        tick();

        // read in flight across a reset is dropped; rotation restarts at 0
        rd(0, 'h14); tick(); clr();
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("drop_rsp", rsp_valid, 0);
            tick();
        end
        for (int i = 0; i < NB; i++) rd(i, 'h15 + i);
        @(negedge clk);
        chk("post_rst_gnt", req_ready, 3'b001);
        tick(); clr();

`ifdef MEM_ARB_LOCK_EN
        rd(2, 'h30); tick(); clr();
        rd(0, 'h31); req_lock[0] = 1'b1; rd(1, 'h32);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("lock_gnt", req_ready, 3'b001);
            tick();
        end
        req_valid[0] = 1'b0; req_lock[0] = 1'b0;
        @(negedge clk);
        chk("unlock_gnt", req_ready, 3'b010);
        tick(); clr();
`endif

        repeat (LAT + 2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
